temp_bcd_conv: RTL and testbench
================================

// Module: temp_bcd_conv
// PURPOSE
//  Converts a raw DS18B20-format temperature word (16-bit two's complement, 1/16 degC per LSB)
//  into three BCD digits (tens, units, tenths) plus sign/over-range flags.
//  Sits directly upstream of the UART TX stage: temp_hun/temp_ten/temp_unit feed its digit inputs.
//  Outputs are registered and held between conversions, so TX may sample them at any time.
// PARAMETERS
//  CLAMP_MAX  999  saturation limit of the result in tenths of degC (999 = 99.9)
//  ROUND      1    1: round half-up to nearest 0.1 degC (+8 before >>4); 0: truncate
// PORTS
//  clk_in     in   1   system clock
//  rst_in     in   1   synchronous reset, active-high
//  raw_valid  in   1   raw_temp valid strobe; sampled only in IDLE
//  raw_temp   in   16  sensor word, signed, 1/16 degC per LSB
//  temp_hun   out  4   BCD tens digit
//  temp_ten   out  4   BCD units digit
//  temp_unit  out  4   BCD tenths digit
//  temp_neg   out  1   result is negative and nonzero
//  over_range out  1   magnitude exceeded CLAMP_MAX; digits saturated
//  busy       out  1   conversion in progress (state != IDLE)
//  done       out  1   one-cycle pulse on the edge that updates the digit outputs
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, internal registers cleared; an in-flight conversion is aborted, no done.
//  - FSM: IDLE -> SCALE -> CONV (10 cycles) -> DONE -> IDLE.
//  - IDLE: on raw_valid=1, capture sign=raw_temp[15] and mag=|raw_temp| (two's complement if negative,
//    12-bit datapath is sufficient; raw_temp[15:12] beyond sign are ignored for magnitude); go to SCALE.
//  - SCALE: t = ((mag<<3)+(mag<<1) + (ROUND?8:0)) >> 4, computed in 16 bits with no overflow.
//    If t > CLAMP_MAX: t = CLAMP_MAX, ovr = 1, else ovr = 0. Load t (10 bits) into double-dabble shift register.
//  - CONV: 10 iterations, one per cycle: each BCD nibble >= 5 gets +3, then shift left 1.
//  - DONE: register digits, temp_neg = sign & (t != 0) (no "-0.0"), over_range = ovr; done = 1 this edge;
//    next state IDLE.
//  - Timing: raw_valid sampled at edge E0; digits/flags change and done rises at edge E0+12;
//    busy is 1 from E0 to E0+12 and falls at the same edge done rises.
//    Earliest next sample is edge E0+13 (min. period 13 cycles).
//  - raw_valid while busy: ignored, not queued. raw_valid held high: back-to-back conversions every 13 cycles.
//  - raw_temp sampled only at E0; later changes do not affect the running conversion.
//  - Digit outputs, temp_neg and over_range hold their value until the next DONE or reset.
// TESTING
//  1. raw 0x0191 (+25.0625) -> digits 2,5,1; neg 0; ovr 0; done exactly 12 cycles after sample, width 1.
//  2. raw 0xFF5E (-10.125) -> digits 1,0,1; temp_neg 1; ovr 0.
//  3. raw 0x07D0 (+125.0) -> digits 9,9,9; over_range 1; next raw 0x0000 -> 0,0,0 with ovr/neg cleared.
//  4. raw 0x0191 at E0, then raw_valid with raw 0x07D0 at E0+5 -> single done at E0+12, digits 2,5,1 only.
//  5. rst_in pulsed at E0+6 mid-conversion -> next cycle busy 0, digits 0, no done;
//     new raw 0xFF5E converts to 1,0,1 in 12 cycles.
//  6. ROUND=0, raw 0xFFFF -> digits 0,0,0, temp_neg 0; raw_valid held high -> done every 13 cycles.

Source files
------------

// File: rtl/temp_bcd_conv.sv
// DS18B20 temperature word to three BCD digits (tens, units, tenths) plus sign and over-range flags.
// The conversion is a fixed 13-cycle sequence: capture, scale to tenths, 10 double-dabble steps, publish.
module temp_bcd_conv #(
    parameter int unsigned CLAMP_MAX = 999,
    parameter bit          ROUND     = 1'b1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        raw_valid,
    input  logic [15:0] raw_temp,
    output logic [3:0]  temp_hun,
    output logic [3:0]  temp_ten,
    output logic [3:0]  temp_unit,
    output logic        temp_neg,
    output logic        over_range,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCALE = 2'd1,
        ST_CONV  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [15:0] CLAMP_W = 16'(CLAMP_MAX);
    localparam logic [15:0] RND_W   = ROUND ? 16'd8 : 16'd0;

    state_t      state_r;
    logic        sign_r;
    logic [11:0] mag_r;
    logic        ovr_r;
    logic [21:0] dd_r;
    logic [3:0]  iter_r;

    logic [11:0] mag_s;
    logic [15:0] scaled_s;
    logic [9:0]  t_s;
    logic        ovr_s;
    logic        unused_s;

    // One double-dabble step: add 3 to every BCD nibble >= 5, then shift the whole register left.
    function automatic logic [21:0] dd_step(input logic [21:0] v);
        logic [21:0] a;
        a = v;
        for (int i = 0; i < 3; i++) begin
            if (a[10 + 4*i +: 4] >= 4'd5) begin
                a[10 + 4*i +: 4] = a[10 + 4*i +: 4] + 4'd3;
            end else begin
                a[10 + 4*i +: 4] = a[10 + 4*i +: 4];
            end
        end
        return {a[20:0], 1'b0};
    endfunction

    assign unused_s = ^raw_temp[14:12];

    // Magnitude of the incoming word and its value in tenths of a degree, saturated at CLAMP_MAX.
    always_comb begin
        mag_s    = raw_temp[15] ? (12'd0 - raw_temp[11:0]) : raw_temp[11:0];
        scaled_s = (({4'd0, mag_r} << 3) + ({4'd0, mag_r} << 1) + RND_W) >> 4;
        if (scaled_s > CLAMP_W) begin
            t_s   = CLAMP_W[9:0];
            ovr_s = 1'b1;
        end else begin
            t_s   = scaled_s[9:0];
            ovr_s = 1'b0;
        end
    end

    // Conversion sequencer with registered digit, flag and handshake outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r    <= ST_IDLE;
            sign_r     <= 1'b0;
            mag_r      <= 12'd0;
            ovr_r      <= 1'b0;
            dd_r       <= 22'd0;
            iter_r     <= 4'd0;
            temp_hun   <= 4'd0;
            temp_ten   <= 4'd0;
            temp_unit  <= 4'd0;
            temp_neg   <= 1'b0;
            over_range <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (raw_valid) begin
                        sign_r  <= raw_temp[15];
                        mag_r   <= mag_s;
                        busy    <= 1'b1;
                        state_r <= ST_SCALE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SCALE: begin
                    dd_r    <= {12'd0, t_s};
                    ovr_r   <= ovr_s;
                    iter_r  <= 4'd0;
                    state_r <= ST_CONV;
                end
                ST_CONV: begin
                    dd_r   <= dd_step(dd_r);
                    iter_r <= iter_r + 4'd1;
                    if (iter_r == 4'd9) begin
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_CONV;
                    end
                end
                ST_DONE: begin
                    temp_hun   <= dd_r[21:18];
                    temp_ten   <= dd_r[17:14];
                    temp_unit  <= dd_r[13:10];
                    // A zero result is shown unsigned so the display never reads "-0.0".
                    temp_neg   <= sign_r & (dd_r[21:10] != 12'd0);
                    over_range <= ovr_r;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_temp_bcd_conv.sv
// Randomized and directed bench for temp_bcd_conv; a rounding and a truncating instance run side by side
// and are compared against an arithmetic model of the temperature-to-tenths conversion.
module tb_temp_bcd_conv;

    logic        clk_in;
    logic        rst_in;
    logic        raw_valid;
    logic [15:0] raw_temp;

    logic [3:0]  hun_r1, ten_r1, unit_r1, hun_r0, ten_r0, unit_r0;
    logic        neg_r1, ovr_r1, busy_r1, done_r1;
    logic        neg_r0, ovr_r0, busy_r0, done_r0;

    int n_checks;
    int n_errors;

    temp_bcd_conv #(.CLAMP_MAX(999), .ROUND(1'b1)) dut_r1 (
        .clk_in(clk_in), .rst_in(rst_in), .raw_valid(raw_valid), .raw_temp(raw_temp),
        .temp_hun(hun_r1), .temp_ten(ten_r1), .temp_unit(unit_r1),
        .temp_neg(neg_r1), .over_range(ovr_r1), .busy(busy_r1), .done(done_r1)
    );

    temp_bcd_conv #(.CLAMP_MAX(999), .ROUND(1'b0)) dut_r0 (
        .clk_in(clk_in), .rst_in(rst_in), .raw_valid(raw_valid), .raw_temp(raw_temp),
        .temp_hun(hun_r0), .temp_ten(ten_r0), .temp_unit(unit_r0),
        .temp_neg(neg_r0), .over_range(ovr_r0), .busy(busy_r0), .done(done_r0)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected {neg, ovr, tens, units, tenths} from plain arithmetic on degrees.
    function automatic logic [13:0] model(input logic [15:0] raw, input int rnd);
        int mag;
        int t;
        logic ovr;
        logic neg;
        mag = raw[15] ? ((65536 - int'(raw)) % 4096) : (int'(raw) % 4096);
        t   = (mag * 10 + (rnd != 0 ? 8 : 0)) / 16;
        ovr = (t > 999);
        if (ovr) t = 999;
        neg = raw[15] && (t != 0);
        return {neg, ovr, 4'(t / 100), 4'((t / 10) % 10), 4'(t % 10)};
    endfunction

    function automatic logic [13:0] obs_r1();
        return {neg_r1, ovr_r1, hun_r1, ten_r1, unit_r1};
    endfunction

    function automatic logic [13:0] obs_r0();
        return {neg_r0, ovr_r0, hun_r0, ten_r0, unit_r0};
    endfunction

    // Runs one conversion; optionally pulses raw_valid with another word at edge E0+inject.
    task automatic convert(input logic [15:0] raw, input int inject);
        raw_valid = 1'b1;
        raw_temp  = raw;
        @(posedge clk_in);
        #1;
        raw_valid = 1'b0;
        raw_temp  = 16'($urandom);
        check("busy_start", {busy_r1, busy_r0}, 2'b11);
        for (int k = 1; k <= 14; k++) begin
            if (k == inject - 1) begin
                raw_valid = 1'b1;
                raw_temp  = 16'h07D0;
            end
            @(posedge clk_in);
            #1;
            if (k == inject) raw_valid = 1'b0;
            check("done_r1", done_r1, (k == 12));
            check("done_r0", done_r0, (k == 12));
            if (k == 11) check("busy_late", {busy_r1, busy_r0}, 2'b11);
            if (k == 12) begin
                check("busy_end", {busy_r1, busy_r0}, 2'b00);
                check("digits_r1", obs_r1(), model(raw, 1));
                check("digits_r0", obs_r0(), model(raw, 0));
            end
        end
        check("hold_r1", obs_r1(), model(raw, 1));
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk_in);
            #1;
            if (done_r1) begin
                cycles = k;
                break;
            end
        end
    endtask

    initial begin
        int cyc;
        logic [15:0] r;
        n_checks  = 0;
        n_errors  = 0;
        rst_in    = 1'b1;
        raw_valid = 1'b0;
        raw_temp  = 16'h0000;
        repeat (3) @(posedge clk_in);
        #1;
        check("reset_r1", {obs_r1(), busy_r1, done_r1}, 16'd0);
        check("reset_r0", {obs_r0(), busy_r0, done_r0}, 16'd0);
        rst_in = 1'b0;
        @(posedge clk_in);
        #1;

        convert(16'h0191, 0);
        convert(16'hFF5E, 0);
        convert(16'h07D0, 0);
        convert(16'h0000, 0);
        convert(16'h063F, 0);
        convert(16'h0640, 0);
        convert(16'hF9C0, 0);
        convert(16'hFFFF, 0);
        convert(16'h8000, 0);
        convert(16'h7FFF, 0);

        // Second request while busy is dropped; raw_temp changes are ignored.
        convert(16'h0191, 5);

        // Mid-conversion reset aborts cleanly.
        raw_valid = 1'b1;
        raw_temp  = 16'h07D0;
        @(posedge clk_in);
        #1;
        raw_valid = 1'b0;
        repeat (5) @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        check("abort_r1", {obs_r1(), busy_r1, done_r1}, 16'd0);
        check("abort_r0", {obs_r0(), busy_r0, done_r0}, 16'd0);
        cyc = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk_in);
            #1;
            if (done_r1 || done_r0 || busy_r1) cyc++;
        end
        check("abort_quiet", cyc, 0);
        convert(16'hFF5E, 0);

        // raw_valid held high gives a done every 13 cycles.
        raw_valid = 1'b1;
        raw_temp  = 16'hFFFF;
        wait_done(cyc);
        check("held_first", cyc, 13);
        for (int p = 0; p < 3; p++) begin
            wait_done(cyc);
            check("held_period", cyc, 13);
            check("held_r0", obs_r0(), model(16'hFFFF, 0));
            check("held_r1", obs_r1(), model(16'hFFFF, 1));
        end
        raw_valid = 1'b0;
        repeat (14) @(posedge clk_in);
        #1;

        for (int i = 0; i < 25; i++) begin
            r = 16'($urandom);
            if (i % 5 == 0) r = 16'(16'h0630 + 16'($urandom_range(0, 31)));
            if (i % 5 == 1) r = 16'(16'hF9B0 + 16'($urandom_range(0, 31)));
            convert(r, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, expected finish before 2000000");
        $fatal(1);
    end

endmodule
